// File: rtl/alu4_arbiter.sv
// alu4_arbiter: shares one combinational alu4 between two requesters.
// Round-robin grant, valid/ready operand handshake, registered operands into
// the ALU and a registered, tagged result (value, zero and overflow flags).
// Optional feature macro: ALU_ARB_OVF_STICKY_EN adds a sticky overflow flag
// (output ovf_sticky) with a clear input (ovf_clr).
module alu4_arbiter #(
  parameter int unsigned W     = 4,
  parameter int unsigned FIRST = 0
) (
  input  logic         clk,
  input  logic         rst,
  // requester 0
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req0_i3,
  input  logic [1:0]   req0_op,
  input  logic         req0_add_sub,
  // requester 1
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [W-1:0] req1_i3,
  input  logic [1:0]   req1_op,
  input  logic         req1_add_sub,
  // response
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_f,
  output logic         rsp_zero,
  output logic         rsp_ovf,
  // alu4 interface
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [W-1:0] alu_i3,
  output logic [1:0]   alu_op,
  output logic         alu_add_sub,
  input  logic [W-1:0] alu_f,
  input  logic         alu_zero,
  input  logic         alu_ovf
`ifdef ALU_ARB_OVF_STICKY_EN
  ,
  output logic         ovf_sticky,
  input  logic         ovf_clr
`endif
);

  localparam logic FirstSel = (FIRST != 0);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  state_e state_q, state_d;

  // Round-robin pointer: the requester that wins when both are valid.
  logic rr_q, rr_d;

  // Operand registers.
  logic         id_q, id_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] i3_q, i3_d;
  logic [1:0]   op_q, op_d;
  logic         as_q, as_d;

  // Result registers.
  logic [W-1:0] res_f_q, res_f_d;
  logic         res_zero_q, res_zero_d;
  logic         res_ovf_q, res_ovf_d;

  logic gnt_any;
  logic gnt_id;
  logic accept;

  // Grant selection; ready is withheld during reset so no handshake is lost.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    gnt_id  = (req0_valid & req1_valid) ? rr_q : req1_valid;
    accept  = (state_q == StIdle) & gnt_any & ~rst;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (gnt_any) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Operand/result capture and pointer update.
  always_comb begin
    rr_d       = rr_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    i3_d       = i3_q;
    op_d       = op_q;
    as_d       = as_q;
    res_f_d    = res_f_q;
    res_zero_d = res_zero_q;
    res_ovf_d  = res_ovf_q;
    if (accept) begin
      id_d = gnt_id;
      if (gnt_id) begin
        a_d  = req1_a;
        b_d  = req1_b;
        i3_d = req1_i3;
        op_d = req1_op;
        as_d = req1_add_sub;
      end else begin
        a_d  = req0_a;
        b_d  = req0_b;
        i3_d = req0_i3;
        op_d = req0_op;
        as_d = req0_add_sub;
      end
    end
    if (state_q == StExec) begin
      res_f_d    = alu_f;
      res_zero_d = alu_zero;
      res_ovf_d  = alu_ovf;
    end
    // Favour the requester that was not just served.
    if ((state_q == StResp) && rsp_ready) begin
      rr_d = ~id_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_q       <= FirstSel;
      id_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      i3_q       <= '0;
      op_q       <= '0;
      as_q       <= 1'b0;
      res_f_q    <= '0;
      res_zero_q <= 1'b0;
      res_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      id_q       <= id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      i3_q       <= i3_d;
      op_q       <= op_d;
      as_q       <= as_d;
      res_f_q    <= res_f_d;
      res_zero_q <= res_zero_d;
      res_ovf_q  <= res_ovf_d;
    end
  end

  // Outputs: ALU inputs only live in EXEC, response only live in RESP.
  always_comb begin
    req0_ready  = accept & ~gnt_id;
    req1_ready  = accept & gnt_id;
    rsp_valid   = (state_q == StResp);
    rsp_id      = rsp_valid ? id_q : 1'b0;
    rsp_f       = rsp_valid ? res_f_q : '0;
    rsp_zero    = rsp_valid ? res_zero_q : 1'b0;
    rsp_ovf     = rsp_valid ? res_ovf_q : 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_i3      = '0;
    alu_op      = '0;
    alu_add_sub = 1'b0;
    if (state_q == StExec) begin
      alu_a       = a_q;
      alu_b       = b_q;
      alu_i3      = i3_q;
      alu_op      = op_q;
      alu_add_sub = as_q;
    end
  end

`ifdef ALU_ARB_OVF_STICKY_EN
  logic sticky_q, sticky_d;

  // Sticky overflow: a set on the same edge as a clear wins.
  always_comb begin
    sticky_d = sticky_q;
    if (ovf_clr) sticky_d = 1'b0;
    if ((state_q == StExec) && alu_ovf) sticky_d = 1'b1;
  end

  // Sticky overflow register.
  always_ff @(posedge clk) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign ovf_sticky = sticky_q;
`endif

endmodule
